// File: rtl/unit_div_seq.sv
// -----------------------------------------------------------------------------
// unit_div_seq
//   Sequential restoring shift-subtract divider. Produces one quotient bit per
//   clock, then a one-cycle sign-fix step, then a one-cycle done pulse.
//
//   Compile-time option:
//     UNIT_DIV_SIGNED_EN  defined   -> sgn selects two's-complement operands
//                         undefined -> sgn ignored, operands always unsigned
//
//   Handshake: start is sampled only in IDLE; the edge that samples it also
//   captures a/b/sgn. Exactly WIDTH+2 edges later done is high for one cycle
//   (2 edges for a zero divisor), and q/r/div_zero are valid and held until
//   the next result is produced. start outside IDLE is dropped, not queued.
//
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     start, a, b, sgn request and operands
//     busy            RUN or FIX in progress (never set for a zero divisor)
//     done            one-cycle result strobe
//     q, r, div_zero  quotient, remainder, divide-by-zero flag
//     dbg_state       current FSM state (IDLE=0, RUN=1, FIX=2, DONE=3)
//
//   WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module unit_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [CW-1:0]    cnt;      // iteration index 0..WIDTH-1
    logic             zero_op;  // current operation is a divide-by-zero

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef UNIT_DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;
    logic neg_a;
    logic neg_b;
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
`endif

    assign dbg_state = state;

    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        // Bit WIDTH of the difference is the borrow: set means trial < 0.
        trial   = shifted - {1'b0, dvs};
`ifdef UNIT_DIV_SIGNED_EN
        neg_a  = sgn & a[WIDTH-1];
        neg_b  = sgn & b[WIDTH-1];
        // The most negative value maps to itself, which is its correct
        // unsigned magnitude, so MIN / -1 needs no special handling.
        load_a = neg_a ? -a : a;
        load_b = neg_b ? -b : b;
        q_fix  = q_neg ? -dvd : dvd;
        r_fix  = r_neg ? -rem : rem;
`else
        load_a = a;
        load_b = b;
        q_fix  = dvd;
        r_fix  = rem;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            zero_op  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
`ifdef UNIT_DIV_SIGNED_EN
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (b != '0) begin
                            dvd     <= load_a;
                            dvs     <= load_b;
                            rem     <= '0;
                            zero_op <= 1'b0;
                            busy    <= 1'b1;
`ifdef UNIT_DIV_SIGNED_EN
                            q_neg   <= neg_a ^ neg_b;
                            r_neg   <= neg_a;
`endif
                            state   <= RUN;
                        end else begin
                            // Zero divisor: park the raw dividend as the
                            // remainder and spend one cycle in FIX (busy stays
                            // low) so done lands two edges after start.
                            dvd     <= '0;
                            dvs     <= '0;
                            rem     <= a;
                            zero_op <= 1'b1;
`ifdef UNIT_DIV_SIGNED_EN
                            q_neg   <= 1'b0;
                            r_neg   <= 1'b0;
`endif
                            state   <= FIX;
                        end
                    end
                end
                RUN: begin
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q        <= zero_op ? '1 : q_fix;
                    r        <= r_fix;
                    div_zero <= zero_op;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
